tick_event_scheduler: RTL and testbench

- Divides the slow-counter one-second/turbo tick pulse into per-channel game events: alien march, alien fire, UFO spawn and shield blink.
- Each channel has a programmable period in ticks.
- Expired channels are shared onto a single event strobe, one grant per clock, by round-robin arbitration. This protects the single downstream consumer (random generator / sprite bus) from simultaneous events.
- Drives the counter's turbo input from the game level.

---
 rtl/tick_event_scheduler.sv | 129 ++++++++++++
 tb/tb_tick_event_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_event_scheduler.sv
// tick_event_scheduler: per-channel tick dividers feeding a
// round-robin arbiter that issues one registered event per clock.
module tick_event_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int TURBO_LEVEL = 4
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      tick,
    input  logic                      pause,
    input  logic [NUM_CH-1:0]         chan_en,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic [3:0]                level,
    output logic                      turbo,
    output logic                      event_valid,
    output logic [$clog2(NUM_CH)-1:0] event_id,
    output logic [NUM_CH-1:0]         event_onehot,
    output logic [NUM_CH-1:0]         overrun
);

    localparam int ID_W = $clog2(NUM_CH);

    logic [CNT_W-1:0]  r_period [NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [ID_W-1:0]   r_rr;

    logic [NUM_CH-1:0] w_cfg_hit;
    logic [NUM_CH-1:0] w_count;
    logic [NUM_CH-1:0] w_expire;
    logic [NUM_CH-1:0] w_grant;
    logic [ID_W-1:0]   w_sel;
    logic              w_found;

    // Per-channel qualifiers; compare is one bit wider so a full-scale period never wraps
    always_comb begin
        w_cfg_hit = '0;
        w_count   = '0;
        w_expire  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfg_hit[i] = cfg_we && (cfg_ch == ID_W'(i));
            w_count[i]   = tick && !pause && chan_en[i]
                           && (r_period[i] != '0) && !w_cfg_hit[i];
            w_expire[i]  = w_count[i]
                           && (({1'b0, r_cnt[i]} + (CNT_W+1)'(1))
                               >= {1'b0, r_period[i]});
        end
    end

    // Round-robin pick: first pending channel at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr;
        w_grant = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && r_pending[ID_W'((int'(r_rr) + k) % NUM_CH)]) begin
                w_found = 1'b1;
                w_sel   = ID_W'((int'(r_rr) + k) % NUM_CH);
            end
        end
        if (w_found) begin
            w_grant = NUM_CH'(1) << w_sel;
        end
    end

    // Period, tick counter, pending and sticky overrun bookkeeping
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i] <= CNT_W'(1);
                r_cnt[i]    <= '0;
            end
            r_pending <= '0;
            overrun   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_period[i] <= cfg_period;
                end

                if (!chan_en[i] || w_cfg_hit[i] || w_expire[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_count[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end

                if (!chan_en[i] || w_cfg_hit[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (w_expire[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end

                if (w_cfg_hit[i]) begin
                    overrun[i] <= 1'b0;
                end else if (w_expire[i] && r_pending[i] && !w_grant[i]) begin
                    overrun[i] <= 1'b1;
                end
            end
        end
    end

    // Registered event strobe, pointer advance and turbo request
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            event_valid  <= 1'b0;
            event_id     <= '0;
            event_onehot <= '0;
            r_rr         <= '0;
            turbo        <= 1'b0;
        end else begin
            turbo <= (int'(level) >= TURBO_LEVEL) && !pause;
            if (w_found) begin
                event_valid  <= 1'b1;
                event_id     <= w_sel;
                event_onehot <= w_grant;
                r_rr         <= ID_W'((int'(w_sel) + 1) % NUM_CH);
            end else begin
                event_valid  <= 1'b0;
                event_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// tb_tick_event_scheduler: vector table, hand sequences and a
// randomized scoreboard run against a tick-count reference model.
`timescale 1ns/1ps
module tb_tick_event_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] chan_en = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0;
    logic [3:0] level = '0;
    logic       turbo;
    logic       event_valid;
    logic [1:0] event_id;
    logic [3:0] event_onehot;
    logic [3:0] overrun;

    tick_event_scheduler #(.NUM_CH(4), .CNT_W(8), .TURBO_LEVEL(4)) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .pause(pause),
        .chan_en(chan_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .level(level), .turbo(turbo),
        .event_valid(event_valid), .event_id(event_id),
        .event_onehot(event_onehot), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: ticks counted since last config, expiry on multiples
    int m_per [N];
    int tk [N];
    int m_rr;
    int exp_q [$];
    int ev_cnt [N];

    typedef struct {
        logic       tick;
        logic       pause;
        logic       we;
        logic [1:0] ch;
        logic [7:0] per;
        logic [3:0] lv;
        logic       ev;
        logic [1:0] id;
        logic [3:0] oh;
        logic       tb;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_per[i] = 1;
            tk[i] = 0;
            ev_cnt[i] = 0;
        end
        m_rr = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick = 0; pause = 0; cfg_we = 0; chan_en = '0; level = '0;
        cyc();
        cyc();
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic t, input logic p, input logic [3:0] en,
                        input logic we, input int ch, input int per,
                        input logic [3:0] lv);
        logic exp_turbo;
        logic [N-1:0] ex;
        int id;
        tick = t; pause = p; chan_en = en; cfg_we = we;
        cfg_ch = 2'(ch); cfg_period = 8'(per); level = lv;
        exp_turbo = (lv >= 4) && !p;
        cyc();
        if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            chk("ev_valid", event_valid, 1);
            chk("ev_id", event_id, id);
            chk("ev_onehot", event_onehot, 1 << id);
            ev_cnt[id]++;
            m_rr = (id + 1) % N;
        end else begin
            chk("ev_idle_valid", event_valid, 0);
            chk("ev_idle_onehot", event_onehot, 0);
        end
        chk("turbo", turbo, exp_turbo);
        chk("overrun_clear", overrun, 0);
        ex = '0;
        for (int i = 0; i < N; i++) if (!en[i]) tk[i] = 0;
        if (we) begin
            m_per[ch] = per;
            tk[ch] = 0;
        end
        if (t && !p) begin
            for (int i = 0; i < N; i++) begin
                if (en[i] && m_per[i] != 0 && !(we && ch == i)) begin
                    tk[i]++;
                    if (tk[i] % m_per[i] == 0) ex[i] = 1'b1;
                end
            end
            for (int k = 0; k < N; k++)
                if (ex[(m_rr + k) % N]) exp_q.push_back((m_rr + k) % N);
        end
        tick = 0; cfg_we = 0;
    endtask

    task automatic idle(input int n, input logic [3:0] en,
                        input logic [3:0] lv);
        repeat (n) step(0, 0, en, 0, 0, 0, lv);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int base;
        int b2;
        int p2 [N];
        int e2 [N];
        logic [3:0] en;

        // back-to-back ticks, all periods 1: overrun, cfg clear, turbo
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 4'b1110};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 0, 4'b1110};
        tbl[3] = '{0, 0, 1, 2, 1, 0, 1, 2, 4'b0100, 0, 4'b1010};
        tbl[4] = '{0, 0, 0, 0, 0, 7, 1, 3, 4'b1000, 1, 4'b1010};
        tbl[5] = '{0, 1, 0, 0, 0, 7, 1, 0, 4'b0001, 0, 4'b1010};
        tbl[6] = '{0, 0, 0, 0, 0, 7, 0, 0, 4'b0000, 1, 4'b1010};
        tbl[7] = '{0, 0, 0, 0, 0, 3, 0, 0, 4'b0000, 0, 4'b1010};
        tbl[8] = '{0, 0, 0, 0, 0, 4, 0, 0, 4'b0000, 1, 4'b1010};

        // reset state and single-channel latency
        do_reset();
        chk("rst_valid", event_valid, 0);
        chk("rst_id", event_id, 0);
        chk("rst_onehot", event_onehot, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_turbo", turbo, 0);
        chan_en = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick = 1;
            cyc();
            tick = 0;
            chk("t1_pre", event_valid, 0);
            cyc();
            chk("t1_valid", event_valid, 1);
            chk("t1_id", event_id, 0);
            chk("t1_onehot", event_onehot, 4'b0001);
            cyc();
            chk("t1_post", event_valid, 0);
            repeat (7) cyc();
        end

        // vector table
        do_reset();
        chan_en = 4'b1111;
        for (int r = 0; r < 9; r++) begin
            tick = tbl[r].tick; pause = tbl[r].pause;
            cfg_we = tbl[r].we; cfg_ch = tbl[r].ch;
            cfg_period = tbl[r].per; level = tbl[r].lv;
            cyc();
            chk($sformatf("tbl%0d_valid", r), event_valid, tbl[r].ev);
            if (tbl[r].ev) chk($sformatf("tbl%0d_id", r), event_id, tbl[r].id);
            chk($sformatf("tbl%0d_onehot", r), event_onehot, tbl[r].oh);
            chk($sformatf("tbl%0d_turbo", r), turbo, tbl[r].tb);
            chk($sformatf("tbl%0d_overrun", r), overrun, tbl[r].ovr);
        end
        tick = 0; pause = 0; cfg_we = 0; level = 0;

        // periods {2,3,4,6}, 12 ticks
        do_reset();
        p2 = '{2, 3, 4, 6};
        e2 = '{6, 4, 3, 2};
        en = 4'b1111;
        for (int i = 0; i < N; i++) step(0, 0, en, 1, i, p2[i], 0);
        for (int t = 0; t < 12; t++) begin
            step(1, 0, en, 0, 0, 0, 0);
            idle(9, en, 0);
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("t2_count_ch%0d", i), ev_cnt[i], e2[i]);

        // config write coincident with a tick
        base = ev_cnt[1];
        step(1, 0, en, 1, 1, 5, 0);
        idle(9, en, 0);
        for (int t = 0; t < 5; t++) begin
            step(1, 0, en, 0, 0, 0, 0);
            idle(9, en, 0);
            if (t == 3) chk("t4_ch1_after4", ev_cnt[1] - base, 0);
        end
        chk("t4_ch1_after5", ev_cnt[1] - base, 1);

        // pause with events outstanding
        step(0, 0, en, 1, 0, 1, 7);
        step(0, 0, en, 1, 1, 1, 7);
        step(0, 0, en, 1, 2, 2, 7);
        step(0, 0, en, 1, 3, 2, 7);
        b2 = ev_cnt[2];
        step(1, 0, en, 0, 0, 0, 7);
        for (int j = 0; j < 8; j++) begin
            step(j % 2 == 0, 1, en, 0, 0, 0, 7);
            chk("t5_turbo_paused", turbo, 0);
        end
        chk("t5_ch2_held", ev_cnt[2] - b2, 0);
        step(0, 0, en, 0, 0, 0, 7);
        chk("t5_turbo_release", turbo, 1);
        step(1, 0, en, 0, 0, 0, 7);
        idle(6, en, 7);
        chk("t5_ch2_after", ev_cnt[2] - b2, 1);

        // reset while events are pending
        for (int i = 0; i < N; i++) step(0, 0, en, 1, i, 1, 0);
        step(1, 0, 4'b0111, 0, 0, 0, 7);
        #1;
        resetN = 1'b0;
        #1;
        chk("t6_valid", event_valid, 0);
        chk("t6_id", event_id, 0);
        chk("t6_onehot", event_onehot, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_turbo", turbo, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        idle(6, 4'b0111, 0);
        step(1, 0, 4'b0111, 0, 0, 0, 0);
        idle(6, 4'b0111, 0);
        chk("t6_replay_ch2", ev_cnt[2], 1);

        // randomized phases
        for (int ph = 0; ph < 6; ph++) begin
            en = 4'($urandom);
            for (int i = 0; i < N; i++)
                step(0, 0, en, 1, i, $urandom_range(0, 7), 4'($urandom));
            for (int t = 0; t < 10; t++) begin
                step(1, $urandom_range(0, 4) == 0, en, 0, 0, 0, 4'($urandom));
                repeat ($urandom_range(5, 8))
                    step(0, 1'($urandom_range(0, 1)), en, 0, 0, 0, 4'($urandom));
            end
        end

        // full-scale period
        en = 4'b0001;
        step(0, 0, en, 1, 0, 255, 0);
        base = ev_cnt[0];
        for (int t = 0; t < 255; t++) begin
            step(1, 0, en, 0, 0, 0, 0);
            idle(5, en, 0);
            if (t == 253) chk("t7_before", ev_cnt[0] - base, 0);
        end
        chk("t7_at255", ev_cnt[0] - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
